pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Sirius core. It arbitrates stall requests from ID and EX into one per-stage stall vector. It also sequences the multi-cycle divider on behalf of EX: operand latch, start/ready handshake, result hand-back, and abort on pipeline flush. It sits beside the pipeline registers and drives their stall inputs.

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stall requests, flush, divider operand/result handshake and stall outputs.
// The slave modport is the pipe_ctrl side; the master modport is the pipeline/divider side.
interface pipe_ctrl_if;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        flush_i;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] div_opdata1_i;
  logic [31:0] div_opdata2_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic [63:0] div_result_o;
  logic        div_done_o;
  logic        div_timeout_o;
  logic [5:0]  stall_o;
  logic [31:0] stall_cnt_o;

  modport slave (
    input  stallreq_id_i, stallreq_ex_i, flush_i, div_req_i, div_signed_i,
    input  div_opdata1_i, div_opdata2_i, div_ready_i, div_result_i,
    output div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
    output div_result_o, div_done_o, div_timeout_o, stall_o, stall_cnt_o
  );

  modport master (
    output stallreq_id_i, stallreq_ex_i, flush_i, div_req_i, div_signed_i,
    output div_opdata1_i, div_opdata2_i, div_ready_i, div_result_i,
    input  div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
    input  div_result_o, div_done_o, div_timeout_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Sirius pipeline control: merges ID/EX stall requests and sequences the multi-cycle divider (IDLE/BUSY/DONE).
// Optional STALL_PERF_EN adds a saturating stalled-cycle counter on stall_cnt_o; otherwise it reads 0.
module pipe_ctrl #(
  parameter int unsigned DIV_MAX_CYC = 40
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q,   state_d;
  logic        start_q,   start_d;
  logic        signed_q,  signed_d;
  logic [31:0] op1_q,     op1_d;
  logic [31:0] op2_q,     op2_d;
  logic [63:0] result_q,  result_d;
  logic        done_q,    done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [5:0]  stall;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    result_d  = result_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    // Flush beats ready and timeout arriving in the same cycle.
    if (bus.flush_i) begin
      state_d   = IDLE;
      start_d   = 1'b0;
      tmo_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.div_req_i) begin
            if (bus.div_opdata2_i == 32'd0) begin
              state_d  = DONE;
              result_d = '0;
              done_d   = 1'b1;
            end else begin
              state_d   = BUSY;
              start_d   = 1'b1;
              signed_d  = bus.div_signed_i;
              op1_d     = bus.div_opdata1_i;
              op2_d     = bus.div_opdata2_i;
              tmo_cnt_d = '0;
            end
          end
        end
        BUSY: begin
          if (bus.div_ready_i) begin
            state_d  = DONE;
            start_d  = 1'b0;
            result_d = bus.div_result_i;
            done_d   = 1'b1;
          end else if (tmo_cnt_q == 32'(DIV_MAX_CYC - 1)) begin
            state_d   = DONE;
            start_d   = 1'b0;
            result_d  = '1;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      result_q  <= result_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A divide stops stalling in DONE so the instruction leaves EX with its result.
  always_comb begin
    stall = 6'b000000;
    if (rst || bus.flush_i)
      stall = 6'b000000;
    else if (bus.stallreq_ex_i || (bus.div_req_i && state_q != DONE))
      stall = 6'b001111;
    else if (bus.stallreq_id_i)
      stall = 6'b000111;
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = 32'h0;
`endif

  assign bus.stall_o       = stall;
  assign bus.div_start_o   = start_q;
  assign bus.div_signed_o  = signed_q;
  assign bus.div_opdata1_o = op1_q;
  assign bus.div_opdata2_o = op2_q;
  assign bus.div_result_o  = result_q;
  assign bus.div_done_o    = done_q;
  assign bus.div_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl: the driver plans whole divide transactions and
// queues per-cycle and per-completion expectations; a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int MAXC = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl #(.DIV_MAX_CYC(MAXC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [5:0]  stall;
    logic        start;
    logic        done;
    logic        chk_ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
  } cyc_t;
  typedef struct {
    logic [63:0] res;
    logic        tmo;
  } cmp_t;

  cyc_t cyc_q[$];
  cmp_t cmp_q[$];
  int nvec = 0;
  int nerr = 0;
  int stall_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall(input logic fl, input logic ex, input logic id, input logic divc);
    if (fl) return 6'b000000;
    if (ex || divc) return 6'b001111;
    if (id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic push(input logic [5:0] st, input logic start, input logic done,
                      input logic ops, input logic [31:0] a, input logic [31:0] b, input logic s);
    cyc_t c;
    c.stall = st; c.start = start; c.done = done; c.chk_ops = ops;
    c.op1 = a; c.op2 = b; c.sgn = s;
    cyc_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side();
    bus.stallreq_id_i = 1'($urandom_range(0, 1));
    bus.stallreq_ex_i = ($urandom_range(0, 3) == 0);
    bus.div_ready_i   = ($urandom_range(0, 3) == 0);
    bus.div_result_i  = {$urandom, $urandom};
  endtask

  // Cycles with no divide in EX: only the plain stall requests matter, ready is ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rand_side();
      bus.div_req_i = 1'b0;
      bus.flush_i   = ($urandom_range(0, 5) == 0);
      push(exp_stall(bus.flush_i, bus.stallreq_ex_i, bus.stallreq_id_i, 1'b0), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      tick();
    end
    bus.flush_i = 1'b0;
  endtask

  // rdy_at / flush_at: BUSY cycle (1-based) where ready / flush is raised; 0 = never.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int rdy_at, input int flush_at, input logic [63:0] res);
    bit finished = 0;
    bit aborted  = 0;
    rand_side();
    bus.flush_i = 1'b0;
    bus.div_req_i = 1'b1;
    bus.div_signed_i = s;
    bus.div_opdata1_i = a;
    bus.div_opdata2_i = b;
    push(6'b001111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    if (b == 32'd0) begin
      cmp_q.push_back('{res: 64'h0, tmo: 1'b0});
    end else begin
      for (int k = 1; !finished; k++) begin
        rand_side();
        bus.div_opdata1_i = $urandom;
        bus.div_opdata2_i = $urandom;
        bus.div_signed_i  = 1'($urandom_range(0, 1));
        bus.flush_i     = (k == flush_at);
        bus.div_ready_i = (k == rdy_at);
        bus.div_result_i = (k == rdy_at) ? res : {$urandom, $urandom};
        push(bus.flush_i ? 6'b000000 : 6'b001111, 1'b1, 1'b0, 1'b1, a, b, s);
        tick();
        if (k == flush_at) begin
          finished = 1; aborted = 1;
        end else if (k == rdy_at) begin
          cmp_q.push_back('{res: res, tmo: 1'b0});
          finished = 1;
        end else if (k == MAXC) begin
          cmp_q.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFF, tmo: 1'b1});
          finished = 1;
        end
      end
    end
    bus.flush_i = 1'b0;
    if (!aborted) begin
      rand_side();
      bus.div_req_i = 1'b1;
      push(exp_stall(1'b0, bus.stallreq_ex_i, bus.stallreq_id_i, 1'b0), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      tick();
    end
    bus.div_req_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      cyc_t c;
      c = cyc_q.pop_front();
      chk("stall_o", 64'(bus.stall_o), 64'(c.stall));
      chk("div_start_o", 64'(bus.div_start_o), 64'(c.start));
      chk("div_done_o", 64'(bus.div_done_o), 64'(c.done));
      if (c.chk_ops) begin
        chk("div_opdata1_o", 64'(bus.div_opdata1_o), 64'(c.op1));
        chk("div_opdata2_o", 64'(bus.div_opdata2_o), 64'(c.op2));
        chk("div_signed_o", 64'(bus.div_signed_o), 64'(c.sgn));
      end
      if (c.stall[0]) stall_total++;
    end
    if (bus.div_done_o === 1'b1) begin
      if (cmp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done: got done=1 with result %0h, expected no completion", bus.div_result_o);
      end else begin
        cmp_t e;
        e = cmp_q.pop_front();
        chk("div_result_o", bus.div_result_o, e.res);
        chk("div_timeout_o", 64'(bus.div_timeout_o), 64'(e.tmo));
      end
    end
  end

  initial begin
    int rdy, fl;
    logic [31:0] dv;
    rst = 1'b1;
    bus.stallreq_id_i = 1'b1; bus.stallreq_ex_i = 1'b1; bus.flush_i = 1'b0;
    bus.div_req_i = 1'b1; bus.div_signed_i = 1'b1;
    bus.div_opdata1_i = 32'd9; bus.div_opdata2_i = 32'd3;
    bus.div_ready_i = 1'b1; bus.div_result_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_o", 64'(bus.stall_o), 64'h0);
    chk("rst_div_start_o", 64'(bus.div_start_o), 64'h0);
    chk("rst_div_done_o", 64'(bus.div_done_o), 64'h0);
    chk("rst_div_result_o", bus.div_result_o, 64'h0);
    chk("rst_div_opdata1_o", 64'(bus.div_opdata1_o), 64'h0);
    chk("rst_div_opdata2_o", 64'(bus.div_opdata2_o), 64'h0);
    chk("rst_div_signed_o", 64'(bus.div_signed_o), 64'h0);
    chk("rst_div_timeout_o", 64'(bus.div_timeout_o), 64'h0);
    chk("rst_stall_cnt_o", 64'(bus.stall_cnt_o), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.stallreq_id_i = 1'b0; bus.stallreq_ex_i = 1'b0;
    bus.div_req_i = 1'b0; bus.div_ready_i = 1'b0;
    @(negedge clk);
    chk("post_rst_div_start_o", 64'(bus.div_start_o), 64'h0);
    chk("post_rst_div_done_o", 64'(bus.div_done_o), 64'h0);
    @(posedge clk); #1;

    // ID stall for two cycles, then EX and ID together.
    bus.stallreq_id_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(6'b000111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      tick();
    end
    bus.stallreq_ex_i = 1'b1;
    push(6'b001111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    bus.stallreq_id_i = 1'b0; bus.stallreq_ex_i = 1'b0;
    push(6'b000000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();

    do_div(32'd100, 32'd7, 1'b1, 4, 0, 64'h0000_0002_0000_000E);
    idle_cycles(2);
    do_div(32'd55, 32'd0, 1'b0, 0, 0, 64'h0);
    idle_cycles(2);
    do_div(32'd81, 32'd9, 1'b0, 2, 2, 64'h0000_0000_0000_0009);
    idle_cycles(2);
    do_div(32'hDEAD_BEEF, 32'd4, 1'b1, 0, 0, 64'h0);
    idle_cycles(2);

    for (int t = 0; t < 250; t++) begin
      dv   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rdy  = $urandom_range(0, MAXC + 2);
      fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAXC) : 0;
      do_div($urandom, dv, 1'($urandom_range(0, 1)), rdy, fl, {$urandom, $urandom});
      idle_cycles($urandom_range(1, 3));
    end

    rand_side();
    bus.stallreq_id_i = 1'b0; bus.stallreq_ex_i = 1'b0; bus.div_ready_i = 1'b0;
    bus.div_req_i = 1'b0; bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending_cycles", 64'(cyc_q.size()), 64'h0);
    chk("pending_completions", 64'(cmp_q.size()), 64'h0);
`ifdef STALL_PERF_EN
    chk("stall_cnt_o", 64'(bus.stall_cnt_o), 64'(stall_total));
`else
    chk("stall_cnt_o", 64'(bus.stall_cnt_o), 64'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
